mgmt_vector_sequencer: RTL
==========================

Name: mgmt_vector_sequencer

Overview:
- Parametrised on-chip stimulus sequencer for synthesizable testing of the TPM management module.
- Stores up to NUM_VEC command vectors and applies them to the device under test (DUT) in order. Each vector holds a command code, a command parameter and an expected response code.
- Samples the DUT response code after a fixed wait, compares it with the expected code, and keeps pass/fail statistics.
- Replaces hand-set switch stimulus. Sits between the keypress enable and the management module inside a board-level test top.

Parameters:
- NUM_VEC, 16, vector storage depth (2..256); AW = clog2(NUM_VEC) is derived as a localparam.
- CC_W, 32, command code width.
- PARAM_W, 33, command parameter width.
- RC_W, 32, response code width.
- RESP_WAIT, 8, cycles from the DUT start pulse to response sampling (≥1).

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle run/step request (keypress enable_out)
- step_mode  in  1  1 = pause after each vector; 0 = free-run
- run_len  in  AW+1  number of vectors per run; 0 or >NUM_VEC is treated as NUM_VEC
- ld_en  in  1  vector write strobe
- ld_addr  in  AW  vector write address
- ld_data  in  CC_W+PARAM_W+RC_W  {cc, param, expected_rc}
- dut_rc  in  RC_W  DUT response code
- dut_start_n  out  1  active-low one-cycle DUT start pulse
- dut_cc  out  CC_W  applied command code
- dut_param  out  PARAM_W  applied parameter
- busy  out  1  run in progress (any state except IDLE/DONE)
- done  out  1  run complete
- cur_idx  out  AW  index of the vector in flight
- pass_cnt, fail_cnt  out  AW+1 each  run statistics
- last_match  out  1  result of the most recent compare
- first_fail_vld  out  1  a mismatch has occurred this run
- first_fail_idx  out  AW  index of the first mismatch

Behaviour:
- Clock and reset: single clock domain `clock`; reset `reset_n` is asynchronous, active-low. Reset values: all outputs 0 except dut_start_n=1; FSM returns to IDLE. Vector RAM contents are not reset.
- Loading: vectors load while not busy. ld_en while busy is ignored (no write).
- States and transitions:
  - IDLE: on start, clear counters, first_fail_*, last_match; cur_idx=0; go to FETCH.
  - FETCH: one cycle, synchronous RAM read; go to ISSUE.
  - ISSUE: register dut_cc/dut_param from RAM output; dut_start_n=0 for this single cycle; load wait counter with RESP_WAIT-1; go to WAIT.
  - WAIT: decrement the counter; at 0 go to CHECK.
  - CHECK: compare dut_rc with expected_rc (full RC_W bits). Match: pass_cnt+1 and last_match=1. Otherwise fail_cnt+1 and last_match=0; if first_fail_vld=0, latch first_fail_idx=cur_idx and set first_fail_vld. Then:
    - if cur_idx == run_len-1, go to DONE;
    - else if step_mode, go to PAUSE;
    - else cur_idx+1 and go to FETCH.
  - PAUSE: wait for start; then cur_idx+1 and go to FETCH.
  - DONE: done=1; outputs hold. On start, clear done and restart exactly as from IDLE.
- Holding: dut_cc/dut_param hold from ISSUE until the next ISSUE.
- Per-vector latency (free-run): 3+RESP_WAIT cycles from FETCH entry to the next FETCH.
- Boundaries:
  - start while in FETCH/ISSUE/WAIT/CHECK is ignored.
  - start coincident with ld_en in IDLE: the write completes and the run starts; a read of the same address in FETCH returns the new data.
  - run_len is sampled at start; later changes have no effect on the current run.
  - Counters cannot overflow (maximum NUM_VEC fits in AW+1).
  - reset_n low mid-run: immediate abort to reset values, with no further DUT pulse.

Optional Feature:
- Macro: MGMT_SEQ_STOP_ON_FAIL_EN
- Defined: a mismatch in CHECK goes straight to DONE regardless of step_mode or the remaining vectors; cur_idx holds the failing index.
- Undefined: all run_len vectors always execute.

Decomposition:
- Shared package mgmt_pkg:
  - FSM state encoding (IDLE, FETCH, ISSUE, WAIT, CHECK, PAUSE, DONE; 3 bits).
  - TPM response code constants: SUCCESS 0x000, FAILURE 0x101, INITIALIZE 0x100, VALUE 0x084, AUTH_TYPE 0x124.
  - Vector field offsets.
- Sub-module mgmt_seq_vec_ram: simple dual-port RAM, synchronous write and synchronous read, NUM_VEC deep. The sequencer FSM and counters stay in the top of this block.

Test Plan:
- Load 3 vectors (cc 0x144/0x121/0x145, expected 0x000). DUT model returns 0x000. start with step_mode=0 and run_len=3 -> exactly 3 dut_start_n pulses spaced 3+RESP_WAIT cycles; pass_cnt=3, fail_cnt=0, done=1.
- Vector 1 expects 0x101 but the DUT returns 0x100 -> fail_cnt=1, first_fail_vld=1, first_fail_idx=1, last_match ends at 1 after vector 2.
- step_mode=1, run_len=2 -> after vector 0 FSM sits in PAUSE with no pulse for 100 cycles; start -> vector 1 issues; done.
- run_len=0 with NUM_VEC=16 -> 16 pulses; ld_en during the run does not alter RAM (verify by reading back on a second run).
- Assert reset_n low during WAIT of vector 2 -> all outputs at reset values, dut_start_n=1; a fresh start restarts at idx 0.
- With MGMT_SEQ_STOP_ON_FAIL_EN, 4 vectors with a failure on vector 1 -> done after 2 pulses; cur_idx=1, pass_cnt=1, fail_cnt=1.

Source files
------------

// File: rtl/mgmt_pkg.sv
// Shared definitions for the management-module vector sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: FSM state encoding, TPM response code constants, and the bit
// layout of a stored vector word {cc, param, expected_rc}.
package mgmt_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_CHECK = 3'd4,
    ST_PAUSE = 3'd5,
    ST_DONE  = 3'd6
  } state_t;

  // TPM response codes seen on the management interface
  localparam logic [11:0] RC_SUCCESS    = 12'h000;
  localparam logic [11:0] RC_FAILURE    = 12'h101;
  localparam logic [11:0] RC_INITIALIZE = 12'h100;
  localparam logic [11:0] RC_VALUE      = 12'h084;
  localparam logic [11:0] RC_AUTH_TYPE  = 12'h124;

  // Vector word layout, LSB first: expected_rc, then param, then cc.
  localparam int VEC_RC_LSB = 0;

  function automatic int vec_param_lsb(input int rc_w);
    return VEC_RC_LSB + rc_w;
  endfunction

  function automatic int vec_cc_lsb(input int rc_w, input int param_w);
    return VEC_RC_LSB + rc_w + param_w;
  endfunction

endpackage

// File: rtl/mgmt_seq_vec_ram.sv
// Vector store: simple dual-port RAM, one write port and one read port.
// Latency: write lands at the clock edge; read data valid one cycle after rd_en.
// Backpressure: none; writes to addresses >= DEPTH are dropped.
//
// Ports:
//   clock            - system clock
//   wr_en/addr/data  - synchronous write port
//   rd_en/addr       - synchronous read request
//   rd_data          - registered read data, holds between reads
module mgmt_seq_vec_ram #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int DW    = 97
) (
  input  logic          clock,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  localparam int AW1 = AW + 1;
  localparam logic [AW:0] DEPTH_W = AW1'(DEPTH);

  logic [DW-1:0] mem [DEPTH];

  // Storage is deliberately not reset; vectors survive a sequencer reset.
  always_ff @(posedge clock) begin
    if (wr_en && ({1'b0, wr_addr} < DEPTH_W)) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/mgmt_vector_sequencer.sv
// On-chip stimulus sequencer: plays stored vectors into the TPM management module and scores responses.
// Latency: 3+RESP_WAIT cycles per vector in free-run; dut_start_n is a registered pulse seen the cycle after ISSUE.
// Backpressure: none; start is ignored while a vector is in flight, ld_en is ignored while busy.
//
// Optional build macro MGMT_SEQ_STOP_ON_FAIL_EN: a mismatch ends the run at once,
// leaving cur_idx on the failing vector. Without it every run_len vector executes.
//
// Ports:
//   clock, reset_n       - clock and async active-low reset
//   start, step_mode     - run / step request, pause-after-each-vector select
//   run_len              - vectors per run, 0 or > NUM_VEC means NUM_VEC (sampled at start)
//   ld_en/addr/data      - vector load port, data = {cc, param, expected_rc}
//   dut_rc               - response code from the module under test
//   dut_start_n          - one-cycle active-low start to the module under test
//   dut_cc, dut_param    - applied command, held until the next vector issues
//   busy, done, cur_idx  - run status
//   pass_cnt, fail_cnt, last_match, first_fail_vld, first_fail_idx - run statistics
module mgmt_vector_sequencer
  import mgmt_pkg::*;
#(
  parameter int NUM_VEC   = 16,
  parameter int CC_W      = 32,
  parameter int PARAM_W   = 33,
  parameter int RC_W      = 32,
  parameter int RESP_WAIT = 8,
  localparam int AW       = $clog2(NUM_VEC)
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic                      step_mode,
  input  logic [AW:0]               run_len,
  input  logic                      ld_en,
  input  logic [AW-1:0]             ld_addr,
  input  logic [CC_W+PARAM_W+RC_W-1:0] ld_data,
  input  logic [RC_W-1:0]           dut_rc,
  output logic                      dut_start_n,
  output logic [CC_W-1:0]           dut_cc,
  output logic [PARAM_W-1:0]        dut_param,
  output logic                      busy,
  output logic                      done,
  output logic [AW-1:0]             cur_idx,
  output logic [AW:0]               pass_cnt,
  output logic [AW:0]               fail_cnt,
  output logic                      last_match,
  output logic                      first_fail_vld,
  output logic [AW-1:0]             first_fail_idx
);

  localparam int VW        = CC_W + PARAM_W + RC_W;
  localparam int PARAM_LSB = vec_param_lsb(RC_W);
  localparam int CC_LSB    = vec_cc_lsb(RC_W, PARAM_W);
  localparam int AW1       = AW + 1;
  localparam logic [AW:0] MAX_LEN = AW1'(NUM_VEC);
  localparam int WCW       = (RESP_WAIT > 1) ? $clog2(RESP_WAIT) : 1;
  localparam logic [WCW-1:0] WAIT_LOAD = WCW'(RESP_WAIT - 1);

  state_t          state_q, state_d;
  logic [WCW-1:0]  wait_cnt;
  logic [AW-1:0]   last_idx;
  logic [RC_W-1:0] exp_rc;
  logic [VW-1:0]   rd_data;
  logic [AW:0]     eff_len;
  logic            run_start;
  logic            advance;
  logic            rc_match;
  logic            is_last;

  assign busy      = !(state_q == ST_IDLE || state_q == ST_DONE);
  assign done      = (state_q == ST_DONE);
  assign run_start = !busy && start;
  assign rc_match  = (dut_rc == exp_rc);
  assign is_last   = (cur_idx == last_idx);
  assign advance   = (state_d == ST_FETCH) && (state_q == ST_CHECK || state_q == ST_PAUSE);
  assign eff_len   = (run_len == '0 || run_len > MAX_LEN) ? MAX_LEN : run_len;

  // Loads are blocked for the whole run so the vectors in play cannot change under it.
  mgmt_seq_vec_ram #(
    .DEPTH (NUM_VEC),
    .AW    (AW),
    .DW    (VW)
  ) u_vec_ram (
    .clock   (clock),
    .wr_en   (ld_en && !busy),
    .wr_addr (ld_addr),
    .wr_data (ld_data),
    .rd_en   (state_q == ST_FETCH),
    .rd_addr (cur_idx),
    .rd_data (rd_data)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: if (start) state_d = ST_FETCH;
      ST_FETCH:         state_d = ST_ISSUE;
      ST_ISSUE:         state_d = ST_WAIT;
      ST_WAIT:          if (wait_cnt == '0) state_d = ST_CHECK;
      ST_CHECK: begin
        if (is_last) begin
          state_d = ST_DONE;
        end else if (step_mode) begin
          state_d = ST_PAUSE;
        end else begin
          state_d = ST_FETCH;
        end
`ifdef MGMT_SEQ_STOP_ON_FAIL_EN
        if (!rc_match) state_d = ST_DONE;
`endif
      end
      ST_PAUSE:         if (start) state_d = ST_FETCH;
      default:          state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      dut_start_n    <= 1'b1;
      dut_cc         <= '0;
      dut_param      <= '0;
      cur_idx        <= '0;
      last_idx       <= '0;
      pass_cnt       <= '0;
      fail_cnt       <= '0;
      last_match     <= 1'b0;
      first_fail_vld <= 1'b0;
      first_fail_idx <= '0;
      exp_rc         <= '0;
      wait_cnt       <= '0;
    end else begin
      // Pulse is registered together with dut_cc/dut_param so the command is
      // stable during the whole low cycle.
      dut_start_n <= (state_q != ST_ISSUE);

      if (run_start) begin
        cur_idx        <= '0;
        last_idx       <= AW'(eff_len - AW1'(1));
        pass_cnt       <= '0;
        fail_cnt       <= '0;
        last_match     <= 1'b0;
        first_fail_vld <= 1'b0;
        first_fail_idx <= '0;
      end

      if (advance) begin
        cur_idx <= cur_idx + AW'(1);
      end

      if (state_q == ST_ISSUE) begin
        dut_cc    <= rd_data[CC_LSB +: CC_W];
        dut_param <= rd_data[PARAM_LSB +: PARAM_W];
        exp_rc    <= rd_data[VEC_RC_LSB +: RC_W];
        wait_cnt  <= WAIT_LOAD;
      end

      if (state_q == ST_WAIT && wait_cnt != '0) begin
        wait_cnt <= wait_cnt - WCW'(1);
      end

      if (state_q == ST_CHECK) begin
        last_match <= rc_match;
        if (rc_match) begin
          pass_cnt <= pass_cnt + AW1'(1);
        end else begin
          fail_cnt <= fail_cnt + AW1'(1);
          if (!first_fail_vld) begin
            first_fail_vld <= 1'b1;
            first_fail_idx <= cur_idx;
          end
        end
      end
    end
  end

endmodule
